// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event classifier: state encoding and
// default tick constants for a 100 MHz system clock.
package btn_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int DEF_CW           = 26;
  localparam int DEF_LONG_TICKS   = 50_000_000;  // 500 ms
  localparam int DEF_GAP_TICKS    = 25_000_000;  // 250 ms
  localparam int DEF_REPEAT_TICKS = 10_000_000;  // 100 ms

endpackage : btn_event_pkg

// File: rtl/btn_tick_timer.sv
// Clearable saturating up-counter with a terminal-match flag against a
// runtime limit. The count sticks at all-ones instead of wrapping.
module btn_tick_timer #(
  parameter int CW = 26
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic [CW-1:0] limit_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, otherwise increment until saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != {CW{1'b1}}) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i);

endmodule : btn_tick_timer

// File: rtl/btn_event.sv
// Button event classifier: turns a clean button level into one-cycle
// press / release / click / double / long pulses (all registered).
// Optional auto-repeat in the long-hold state is enabled by defining the
// macro BTNEV_REPEAT_EN; without it o_repeat is tied low.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int CW           = DEF_CW,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int GAP_TICKS    = DEF_GAP_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_double,
  output logic o_long,
  output logic o_repeat,
  output logic o_busy
);

  // Terminal values: the counter reads N-1 on the edge where N cycles elapsed.
  localparam logic [CW-1:0] LONG_LIM = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] GAP_LIM  = CW'(GAP_TICKS - 1);

  state_t state_q, state_d;
  logic   second_q, second_d;
  logic   press_q, press_d;
  logic   release_q, release_d;
  logic   click_q, click_d;
  logic   double_q, double_d;
  logic   long_q, long_d;
  logic   repeat_q, repeat_d;
  logic   busy_q;
  logic   cnt_clr_s;
  logic   cnt_tc_s;
  logic [CW-1:0] cnt_lim_s;

  // The main timer compares against whichever limit the current state uses.
  assign cnt_lim_s = (state_q == ST_GAP) ? GAP_LIM : LONG_LIM;
  assign cnt_clr_s = (state_d != state_q);

  btn_tick_timer #(.CW(CW)) u_main_timer (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .clr_i   (cnt_clr_s),
    .limit_i (cnt_lim_s),
    .tc_o    (cnt_tc_s)
  );

`ifdef BTNEV_REPEAT_EN
  localparam logic [CW-1:0] REPEAT_LIM = CW'(REPEAT_TICKS - 1);

  logic rpt_clr_s;
  logic rpt_tc_s;

  // Repeat timer idles at zero outside LONG and restarts after each pulse.
  assign rpt_clr_s = (state_q != ST_LONG) || repeat_d;

  btn_tick_timer #(.CW(CW)) u_repeat_timer (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .clr_i   (rpt_clr_s),
    .limit_i (REPEAT_LIM),
    .tc_o    (rpt_tc_s)
  );

  // Repeat fires only while still held, so a release cycle never repeats.
  always_comb begin
    repeat_d = (state_q == ST_LONG) && i_btn && rpt_tc_s;
  end
`else
  // Auto-repeat disabled: the output stays low.
  always_comb begin
    repeat_d = 1'b0;
  end
`endif

  // Next-state and pulse decode; release beats long, press beats gap timeout.
  always_comb begin
    state_d   = state_q;
    second_d  = second_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_btn) begin
          state_d  = ST_HELD;
          press_d  = 1'b1;
          second_d = 1'b0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (!i_btn) begin
          release_d = 1'b1;
          if (second_q) begin
            state_d  = ST_IDLE;
            double_d = 1'b1;
          end else begin
            state_d  = ST_GAP;
          end
        end else if (cnt_tc_s) begin
          state_d  = ST_LONG;
          long_d   = 1'b1;
          second_d = 1'b0;
        end else begin
          state_d  = ST_HELD;
        end
      end
      ST_LONG: begin
        if (!i_btn) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          state_d   = ST_LONG;
        end
      end
      ST_GAP: begin
        if (i_btn) begin
          state_d  = ST_HELD;
          press_d  = 1'b1;
          second_d = 1'b1;
        end else if (cnt_tc_s) begin
          state_d  = ST_IDLE;
          click_d  = 1'b1;
        end else begin
          state_d  = ST_GAP;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        second_d = 1'b0;
      end
    endcase
  end

  // State, second-press flag and all output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      second_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      second_q  <= second_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      double_q  <= double_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_click   = click_q;
  assign o_double  = double_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;
  assign o_busy    = busy_q;

endmodule : btn_event
